// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_unit_pkg;

   localparam int unsigned PC_WIDTH    = 32;
   localparam logic [31:0] RESET_PC    = 32'h0000_0000;
   localparam int unsigned PC_STEP     = 4;
   localparam int unsigned INSTR_WIDTH = 32;

   // Instruction field positions handed to the control decoder
   localparam int unsigned OPC_MSB   = 31;
   localparam int unsigned OPC_LSB   = 27;
   localparam int unsigned OPC_WIDTH = OPC_MSB - OPC_LSB + 1;
   localparam int unsigned IBIT      = 26;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2
   } state_e;

endpackage

// File: rtl/fetch_unit_branch_resolve.sv
// Resolves branch/call/return controls into a taken flag and redirect target.
module branch_resolve #(
   parameter int unsigned W = fetch_unit_pkg::PC_WIDTH
) (
   input  logic         br_valid,
   input  logic         is_beq,
   input  logic         is_bgt,
   input  logic         is_ubranch,
   input  logic         is_ret,
   input  logic         flag_e,
   input  logic         flag_gt,
   input  logic [W-1:0] branch_target,
   input  logic [W-1:0] ret_addr,
   output logic         taken_c,
   output logic [W-1:0] target_c
);

   always_comb begin
      taken_c  = br_valid & (is_ubranch | (is_beq & flag_e) | (is_bgt & flag_gt));
      target_c = is_ret ? ret_addr : branch_target;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues held memory requests and
// presents one instruction slot to decode, with branch redirect and flush.
module fetch_unit #(
   parameter int unsigned          PC_WIDTH = fetch_unit_pkg::PC_WIDTH,
   parameter logic [PC_WIDTH-1:0]  RESET_PC = PC_WIDTH'(fetch_unit_pkg::RESET_PC),
   parameter int unsigned          PC_STEP  = fetch_unit_pkg::PC_STEP
) (
   input  logic                                  clk,
   input  logic                                  rst,
   output logic                                  imem_req,
   output logic [PC_WIDTH-1:0]                   imem_addr,
   input  logic                                  imem_ack,
   input  logic [fetch_unit_pkg::INSTR_WIDTH-1:0] imem_rdata,
   input  logic                                  stall,
   input  logic                                  br_valid,
   input  logic                                  is_beq,
   input  logic                                  is_bgt,
   input  logic                                  is_ubranch,
   input  logic                                  is_ret,
   input  logic                                  flag_e,
   input  logic                                  flag_gt,
   input  logic [PC_WIDTH-1:0]                   branch_target,
   input  logic [PC_WIDTH-1:0]                   ret_addr,
   output logic                                  if_valid,
   output logic [fetch_unit_pkg::INSTR_WIDTH-1:0] if_instr,
   output logic [PC_WIDTH-1:0]                   if_pc,
   output logic [fetch_unit_pkg::OPC_WIDTH-1:0]   if_opcode,
   output logic                                  if_i,
   output logic                                  redirect
);

   import fetch_unit_pkg::*;

   state_e                 state_q, state_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [PC_WIDTH-1:0]    addr_q, addr_d;
   logic                   if_valid_q, if_valid_d;
   logic [INSTR_WIDTH-1:0] if_instr_q, if_instr_d;
   logic [PC_WIDTH-1:0]    if_pc_q, if_pc_d;
   logic                   redirect_q, redirect_d;

   logic                   taken_c;
   logic [PC_WIDTH-1:0]    target_c;
   logic                   consume_c;
   logic                   imem_req_c;
   logic [PC_WIDTH-1:0]    imem_addr_c;

   branch_resolve #(.W(PC_WIDTH)) u_branch_resolve (
      .br_valid      (br_valid),
      .is_beq        (is_beq),
      .is_bgt        (is_bgt),
      .is_ubranch    (is_ubranch),
      .is_ret        (is_ret),
      .flag_e        (flag_e),
      .flag_gt       (flag_gt),
      .branch_target (branch_target),
      .ret_addr      (ret_addr),
      .taken_c       (taken_c),
      .target_c      (target_c)
   );

   assign consume_c = if_valid_q & ~stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         addr_q     <= RESET_PC;
         if_valid_q <= 1'b0;
         if_instr_q <= '0;
         if_pc_q    <= '0;
         redirect_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         if_valid_q <= if_valid_d;
         if_instr_q <= if_instr_d;
         if_pc_q    <= if_pc_d;
         redirect_q <= redirect_d;
      end
   end

   // Next-state, request and slot update; a taken branch overrides everything below reset
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      addr_d      = addr_q;
      if_valid_d  = if_valid_q;
      if_instr_d  = if_instr_q;
      if_pc_d     = if_pc_q;
      redirect_d  = 1'b0;
      imem_req_c  = 1'b0;
      imem_addr_c = pc_q;

      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
         end
         S_REQ: begin
            imem_req_c = ~(if_valid_q & stall);
            addr_d     = pc_q;
            if (taken_c) begin
               // Request already on the bus must be retired before the new PC is used
               if (imem_req_c & ~imem_ack) state_d = S_DROP;
            end else if (imem_req_c & imem_ack) begin
               if_instr_d = imem_rdata;
               if_pc_d    = pc_q;
               if_valid_d = 1'b1;
               pc_d       = pc_q + PC_WIDTH'(PC_STEP);
            end else if (consume_c) begin
               if_valid_d = 1'b0;
            end
         end
         S_DROP: begin
            imem_req_c  = 1'b1;
            imem_addr_c = addr_q;
            if (imem_ack) state_d = S_REQ;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (taken_c) begin
         pc_d       = target_c;
         if_valid_d = 1'b0;
         redirect_d = 1'b1;
      end
   end

   assign imem_req  = imem_req_c;
   assign imem_addr = imem_addr_c;
   assign if_valid  = if_valid_q;
   assign if_instr  = if_instr_q;
   assign if_pc     = if_pc_q;
   assign if_opcode = if_instr_q[OPC_MSB:OPC_LSB];
   assign if_i      = if_instr_q[IBIT];
   assign redirect  = redirect_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: expected instruction stream is
// derived from program-order PCs and a synthetic memory image.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        br_valid, is_beq, is_bgt, is_ubranch, is_ret, flag_e, flag_gt;
   logic [31:0] branch_target, ret_addr;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [4:0]  if_opcode;
   logic        if_i;
   logic        redirect;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .stall         (stall),
      .br_valid      (br_valid),
      .is_beq        (is_beq),
      .is_bgt        (is_bgt),
      .is_ubranch    (is_ubranch),
      .is_ret        (is_ret),
      .flag_e        (flag_e),
      .flag_gt       (flag_gt),
      .branch_target (branch_target),
      .ret_addr      (ret_addr),
      .if_valid      (if_valid),
      .if_instr      (if_instr),
      .if_pc         (if_pc),
      .if_opcode     (if_opcode),
      .if_i          (if_i),
      .redirect      (redirect)
   );

   int          n_checks   = 0;
   int          n_fail     = 0;
   int          n_consumed = 0;
   logic [31:0] exp_q[$];
   bit          mon_en     = 1'b0;
   bit          taken_prev = 1'b0;
   bit          hold_prev  = 1'b0;
   bit          prev_pend  = 1'b0;
   logic [31:0] prev_addr, hold_pc, hold_instr;
   logic [31:0] mon_e, mon_ei;
   bit          mon_tk;

   // Memory image: small addresses follow the 0x0800_0001+addr pattern, the rest are hashed
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a < 32'h1000) return 32'h0800_0001 + a;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
   endfunction

   function automatic bit model_taken();
      return br_valid && (is_ubranch || (is_beq && flag_e) || (is_bgt && flag_gt));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; ack_mode 0=random, 1=always ack, 2=never ack
   task automatic cycle(input bit st, input bit bv, input bit beq, input bit bgt,
                        input bit ub, input bit rt, input bit fe, input bit fg,
                        input logic [31:0] tgt, input logic [31:0] ra, input int ack_mode);
      bit ack;
      @(negedge clk);
      stall = st; br_valid = bv; is_beq = beq; is_bgt = bgt; is_ubranch = ub;
      is_ret = rt; flag_e = fe; flag_gt = fg; branch_target = tgt; ret_addr = ra;
      if (model_taken()) begin
         exp_q.delete();
         exp_q.push_back(rt ? ra : tgt);
      end
      #1;
      case (ack_mode)
         0:       ack = ($urandom_range(0, 3) != 0);
         1:       ack = 1'b1;
         default: ack = 1'b0;
      endcase
      imem_ack   = ack;
      imem_rdata = ack ? mem_word(imem_addr) : $urandom();
   endtask

   task automatic run(input int n, input int ack_mode);
      for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, ack_mode);
   endtask

   // Monitor: samples late in the low phase, after all inputs for the next edge settle
   always @(negedge clk) begin
      #3;
      if (mon_en) begin
         mon_tk = model_taken();
         chk("redirect", 32'(redirect), 32'(taken_prev));
         if (taken_prev) chk("flush_valid", 32'(if_valid), 32'h0);
         if (hold_prev) begin
            chk("hold_valid", 32'(if_valid), 32'h1);
            chk("hold_pc", if_pc, hold_pc);
            chk("hold_instr", if_instr, hold_instr);
         end
         if (if_valid && stall) chk("req_in_stall", 32'(imem_req), 32'h0);
         if (prev_pend && imem_req) chk("req_addr_stable", imem_addr, prev_addr);
         hold_prev = 1'b0;
         if (if_valid && !mon_tk) begin
            if (stall) begin
               hold_prev  = 1'b1;
               hold_pc    = if_pc;
               hold_instr = if_instr;
            end else if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL scoreboard_empty: got pc %h with nothing expected", if_pc);
            end else begin
               mon_e  = exp_q.pop_front();
               mon_ei = mem_word(mon_e);
               chk("if_pc", if_pc, mon_e);
               chk("if_instr", if_instr, mon_ei);
               chk("if_opcode", 32'(if_opcode), 32'(mon_ei[31:27]));
               chk("if_i", 32'(if_i), 32'(mon_ei[26]));
               n_consumed++;
               exp_q.push_back(mon_e + 32'd4);
            end
         end
         taken_prev = mon_tk;
         prev_pend  = imem_req && !imem_ack;
         prev_addr  = imem_addr;
      end
   end

   initial begin
      bit          st, bv;
      logic [31:0] tgt, ra, old_addr;

      rst = 1'b0; stall = 1'b0; br_valid = 1'b0; is_beq = 1'b0; is_bgt = 1'b0;
      is_ubranch = 1'b0; is_ret = 1'b0; flag_e = 1'b0; flag_gt = 1'b0;
      branch_target = '0; ret_addr = '0; imem_ack = 1'b0; imem_rdata = '0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      #3;
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", 32'(if_valid), 32'h0);
      chk("rst_instr", if_instr, 32'h0);
      chk("rst_pc", if_pc, 32'h0);
      chk("rst_opcode", 32'(if_opcode), 32'h0);
      chk("rst_i", 32'(if_i), 32'h0);
      chk("rst_redirect", 32'(redirect), 32'h0);

      @(negedge clk);
      exp_q.push_back(32'h0);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Back-to-back fetch
      run(3, 1);
      #3 chk("seq_count", 32'(n_consumed), 32'd2);

      // Stall while pc 8 sits in the slot
      for (int k = 0; k < 3; k++) begin
         cycle(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
         chk("stall_pc", if_pc, 32'h8);
         chk("stall_req", 32'(imem_req), 32'h0);
      end
      run(2, 1);
      #3 chk("post_stall_count", 32'(n_consumed), 32'd4);

      // beq taken, then beq not taken
      cycle(0, 1, 1, 0, 0, 0, 1, 0, 32'h100, 32'h0, 1);
      run(1, 1);
      chk("beq_fetch_addr", imem_addr, 32'h100);
      run(4, 1);
      cycle(0, 1, 1, 0, 0, 0, 0, 0, 32'h100, 32'h0, 1);
      run(3, 1);

      // Redirect while request is pending: stale address held until ack
      run(2, 1);
      cycle(0, 1, 0, 0, 1, 0, 0, 0, 32'h300, 32'h0, 2);
      old_addr = imem_addr;
      for (int k = 0; k < 2; k++) begin
         cycle(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 2);
         chk("drop_req", 32'(imem_req), 32'h1);
         chk("drop_addr", imem_addr, old_addr);
      end
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
      chk("drop_ack_addr", imem_addr, old_addr);
      run(1, 1);
      chk("drop_target_addr", imem_addr, 32'h300);
      run(4, 1);

      // Return with stall asserted: flush and ret_addr win
      run(3, 1);
      cycle(1, 1, 0, 0, 1, 1, 0, 0, 32'h200, 32'h40, 1);
      run(1, 1);
      chk("ret_addr_fetch", imem_addr, 32'h40);
      chk("ret_req", 32'(imem_req), 32'h1);
      run(4, 1);

      // PC wrap at the top of the address space
      cycle(0, 1, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 1);
      run(1, 1);
      chk("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
      run(1, 1);
      chk("wrap_zero_addr", imem_addr, 32'h0);
      run(3, 1);

      // Asynchronous reset mid-request
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 2);
      chk("pre_rst_req", 32'(imem_req), 32'h1);
      mon_en = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("async_rst_req", 32'(imem_req), 32'h0);
      chk("async_rst_addr", imem_addr, 32'h0);
      chk("async_rst_valid", 32'(if_valid), 32'h0);
      chk("async_rst_pc", if_pc, 32'h0);
      chk("async_rst_redirect", 32'(redirect), 32'h0);
      repeat (2) @(negedge clk);
      exp_q.delete();
      exp_q.push_back(32'h0);
      taken_prev = 1'b0;
      hold_prev  = 1'b0;
      prev_pend  = 1'b0;
      n_consumed = 0;
      rst        = 1'b0;
      mon_en     = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         st  = ($urandom_range(0, 3) == 0);
         bv  = ($urandom_range(0, 7) == 0);
         tgt = (($urandom_range(0, 1) == 0) ? (32'($urandom_range(0, 1023)) << 2)
                                            : ($urandom() & 32'hFFFF_FFFC));
         ra  = 32'($urandom_range(0, 1023)) << 2;
         cycle(st, bv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tgt, ra, 0);
      end
      #3 chk("random_progress", 32'(n_consumed > 300), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
